// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding, debug constants and counter sizing for rst_sequencer.
package rst_seq_pkg;
    localparam logic [2:0] DBG_WAIT_LOCK  = 3'd0;
    localparam logic [2:0] DBG_HOLD_MEM   = 3'd1;
    localparam logic [2:0] DBG_WAIT_CALIB = 3'd2;
    localparam logic [2:0] DBG_HOLD_CORE  = 3'd3;
    localparam logic [2:0] DBG_RUN        = 3'd4;
    localparam logic [2:0] DBG_FAULT      = 3'd5;

    typedef enum logic [2:0] {
        WAIT_LOCK  = DBG_WAIT_LOCK,
        HOLD_MEM   = DBG_HOLD_MEM,
        WAIT_CALIB = DBG_WAIT_CALIB,
        HOLD_CORE  = DBG_HOLD_CORE,
        RUN        = DBG_RUN,
        FAULT      = DBG_FAULT
    } rst_seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain bringing an async level into the clk domain, resets to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[STAGES-2:0], i_d};

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: orders mem/core reset release after PLL lock and calibration.
// Define RST_SEQ_TIMEOUT_EN to enable the calibration timeout and sticky fault.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES          = 2,
    parameter int MEM_HOLD_CYCLES      = 200,
    parameter int CORE_HOLD_CYCLES     = 16,
    parameter int CALIB_TIMEOUT_CYCLES = 65536
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pll_locked,
    input  logic       calib_done,
    output logic       mem_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_dbg
);
    localparam int CW = cnt_width(MEM_HOLD_CYCLES, CORE_HOLD_CYCLES, CALIB_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST = CW'(CORE_HOLD_CYCLES - 1);

    rst_seq_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           w_locked_s, w_calib_s, w_count, w_timeout;
    logic           w_mem_rst_nxt, w_core_rst_nxt, w_ready_nxt, w_fault_nxt;
    logic           r_mem_rst, r_core_rst, r_ready, r_fault;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_d(pll_locked), .o_q(w_locked_s)
    );
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_calib (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_d(calib_done), .o_q(w_calib_s)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT_CYCLES - 1);
    assign w_timeout   = (r_cnt == CALIB_LAST);
    assign w_count     = (r_state == HOLD_MEM) || (r_state == WAIT_CALIB) || (r_state == HOLD_CORE);
    assign w_fault_nxt = (w_state_nxt == FAULT);
`else
    assign w_timeout   = 1'b0;
    assign w_count     = (r_state == HOLD_MEM) || (r_state == HOLD_CORE);
    assign w_fault_nxt = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_mem_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_rst  <= w_mem_rst_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_ready    <= w_ready_nxt;
            r_fault    <= w_fault_nxt;
        end

    // Lock loss outranks every other transition; FAULT only leaves via sys_rst.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_locked_s && r_state != WAIT_LOCK && r_state != FAULT)
            w_state_nxt = WAIT_LOCK;
        else
            case (r_state)
                WAIT_LOCK:  w_state_nxt = w_locked_s ? HOLD_MEM : WAIT_LOCK;
                HOLD_MEM:   w_state_nxt = (r_cnt == MEM_LAST) ? WAIT_CALIB : HOLD_MEM;
                WAIT_CALIB: w_state_nxt = w_calib_s ? HOLD_CORE : w_timeout ? FAULT : WAIT_CALIB;
                HOLD_CORE:  w_state_nxt = !w_calib_s ? WAIT_CALIB : (r_cnt == CORE_LAST) ? RUN : HOLD_CORE;
                RUN:        w_state_nxt = w_calib_s ? RUN : WAIT_CALIB;
                FAULT:      w_state_nxt = FAULT;
                default:    w_state_nxt = WAIT_LOCK;
            endcase
    end

    always_comb begin
        w_cnt_nxt      = (w_state_nxt != r_state) ? '0 :
                         (w_count && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        w_mem_rst_nxt  = (w_state_nxt == WAIT_LOCK) || (w_state_nxt == HOLD_MEM) || (w_state_nxt == FAULT);
        w_core_rst_nxt = (w_state_nxt != RUN);
        w_ready_nxt    = (w_state_nxt == RUN);
    end

    assign mem_rst   = r_mem_rst;
    assign core_rst  = r_core_rst;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign state_dbg = r_state;
endmodule
